traffic_sched: RTL

Intersection scheduler that sequences the four traffic lights on the Nexys3 board, so that at most one approach is ever non-red. It holds a per-light table of green and yellow durations, programmed from the switch/button path (select, color, time value, send strobe). It runs those durations from the board's divided timebase strobe, and is started and paused by the go strobe. Its packed color output drives the light indicators; `active` and `remain` feed the seven-segment display.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/phase_timer.sv | 25 ++
 rtl/traffic_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic_sched block: light color codes, FSM states and default phase durations.
// The ALLRED state exists only when TRAFFIC_SCHED_ALLRED_EN is defined.
package traffic_pkg;

    localparam logic [1:0] RED = 2'b01;
    localparam logic [1:0] YEL = 2'b10;
    localparam logic [1:0] GRN = 2'b11;

    localparam logic [3:0] DEF_GREEN  = 4'd5;
    localparam logic [3:0] DEF_YELLOW = 4'd2;

    typedef enum logic [2:0] {
        IDLE,
        GREEN,
        YELLOW,
`ifdef TRAFFIC_SCHED_ALLRED_EN
        ALLRED,
`endif
        PAUSE
    } state_t;

    // Every light red except light idx, which shows the color of the given phase.
    function automatic logic [7:0] light_pattern(input state_t st, input logic [1:0] idx);
        logic [7:0] pat;
        pat = {4{RED}};
        if (st == GREEN)
            pat[{idx, 1'b0} +: 2] = GRN;
        else if (st == YELLOW)
            pat[{idx, 1'b0} +: 2] = YEL;
        return pat;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Four-bit phase counter: loads a duration (zero forced to 1) and counts it down on unheld ticks.
module phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       tick,
    input  logic       hold,
    output logic [3:0] remain,
    output logic       done
);

    assign done = tick && !hold && (remain == 4'd1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            remain <= 4'd0;
        else if (load)
            remain <= (load_val == 4'd0) ? 4'd1 : load_val;
        else if (tick && !hold && remain != 4'd0)
            remain <= remain - 4'd1;
    end

endmodule

// File: rtl/traffic_sched.sv
// Four-light intersection scheduler: duration table, phase FSM with pause/resume, registered light outputs.
// Define TRAFFIC_SCHED_ALLRED_EN to insert a one-tick all-red clearance phase after every yellow.
module traffic_sched
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       cfg_send,
    input  logic [1:0] cfg_sel,
    input  logic       cfg_color,
    input  logic [3:0] cfg_time,
    input  logic       go,
    output logic [7:0] light_color,
    output logic [1:0] active,
    output logic [3:0] remain,
    output logic       running
);

    state_t     state;
    state_t     saved_state;
    logic [3:0] dur [8];     // index {light, color}: color 0 green, 1 yellow
    logic [1:0] nxt_light;
    logic       load;
    logic [3:0] load_val;
    logic       hold;
    logic       done;

    assign nxt_light = active + 2'd1;
    assign hold      = go || (state == IDLE) || (state == PAUSE);

    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        load     = 1'b0;
        load_val = 4'd0;
        case (state)
            IDLE: if (go) begin
                load     = 1'b1;
                load_val = dur[3'd0];
            end
            GREEN: if (done) begin
                load     = 1'b1;
                load_val = dur[{active, 1'b1}];
            end
            YELLOW: if (done) begin
                load     = 1'b1;
`ifdef TRAFFIC_SCHED_ALLRED_EN
                load_val = 4'd1;
`else
                load_val = dur[{nxt_light, 1'b0}];
`endif
            end
`ifdef TRAFFIC_SCHED_ALLRED_EN
            ALLRED: if (done) begin
                load     = 1'b1;
                load_val = dur[{nxt_light, 1'b0}];
            end
`endif
            default: ;
        endcase
    end

    phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .hold     (hold),
        .remain   (remain),
        .done     (done)
    );

    // The load mux reads the table before this edge, so a write never alters a phase being loaded now.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            saved_state <= IDLE;
            active      <= 2'd0;
            light_color <= {4{RED}};
            running     <= 1'b0;
            // NOTE: the duration table is small and must come back to known defaults, so it is reset explicitly.
            for (int i = 0; i < 8; i++)
                dur[i] <= i[0] ? DEF_YELLOW : DEF_GREEN;
        end else begin
            if (cfg_send)
                dur[{cfg_sel, cfg_color}] <= cfg_time;

            case (state)
                IDLE: if (go) begin
                    state       <= GREEN;
                    active      <= 2'd0;
                    light_color <= light_pattern(GREEN, 2'd0);
                    running     <= 1'b1;
                end
                PAUSE: if (go) begin
                    state   <= saved_state;
                    running <= 1'b1;
                end
                default: begin
                    if (go) begin
                        saved_state <= state;
                        state       <= PAUSE;
                        running     <= 1'b0;
                    end else if (done) begin
                        case (state)
                            GREEN: begin
                                state       <= YELLOW;
                                light_color <= light_pattern(YELLOW, active);
                            end
`ifdef TRAFFIC_SCHED_ALLRED_EN
                            YELLOW: begin
                                state       <= ALLRED;
                                light_color <= {4{RED}};
                            end
`endif
                            default: begin
                                state       <= GREEN;
                                active      <= nxt_light;
                                light_color <= light_pattern(GREEN, nxt_light);
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
